// File: rtl/mem_port_arb.sv
// Dual-lane to single-port memory arbiter. A dual bundle issues the upper access first and
// the lower access one cycle later. Load data returns to the lane that requested it.

module mem_port_arb_lane #(
  parameter logic LANE = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        ret_vld,
  input  logic        ret_lane,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        rvalid
);
  logic hit;

  // A flush on the exit edge kills this return as well.
  assign hit = ret_vld & (ret_lane == LANE) & ~flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= hit;
      if (hit) rdata <= mem_rdata;
    end
  end
endmodule

module mem_port_arb #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        u_req,
  input  logic        l_req,
  input  logic        u_we,
  input  logic        l_we,
  input  logic [31:0] u_addr,
  input  logic [31:0] l_addr,
  input  logic [31:0] u_wdata,
  input  logic [31:0] l_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] u_rdata,
  output logic [31:0] l_rdata,
  output logic        u_rvalid,
  output logic        l_rvalid,
  output logic        interlock
);
  typedef enum logic {IDLE, SECOND} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t             state;
  req_t               pend;
  logic               mem_lane;
  logic               vld_in;
  logic [MEM_LAT:1]   vld_pipe;
  logic [MEM_LAT:1]   lane_pipe;
  logic [1:0][31:0]   rdata_l;
  logic [1:0]         rvalid_l;

  assign interlock = (state == SECOND);
  assign vld_in    = mem_en & ~mem_we;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      pend      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_lane  <= 1'b0;
      vld_pipe  <= '0;
      lane_pipe <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;

      // Tag tracks the access currently on the port; stage MEM_LAT lines up with mem_rdata.
      lane_pipe[1] <= mem_lane;
      for (int i = 2; i <= MEM_LAT; i++) lane_pipe[i] <= lane_pipe[i-1];
      if (flush) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[1] <= vld_in;
        for (int i = 2; i <= MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end

      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (u_req) begin
              mem_en    <= 1'b1;
              mem_we    <= u_we;
              mem_addr  <= u_addr;
              mem_wdata <= u_wdata;
              mem_lane  <= 1'b0;
              if (l_req) begin
                pend  <= '{we: l_we, addr: l_addr, wdata: l_wdata};
                state <= SECOND;
              end
            end else if (l_req) begin
              mem_en    <= 1'b1;
              mem_we    <= l_we;
              mem_addr  <= l_addr;
              mem_wdata <= l_wdata;
              mem_lane  <= 1'b1;
            end
          end
          SECOND: begin
            mem_en    <= 1'b1;
            mem_we    <= pend.we;
            mem_addr  <= pend.addr;
            mem_wdata <= pend.wdata;
            mem_lane  <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Lane 0 = upper, lane 1 = lower.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    mem_port_arb_lane #(.LANE(1'(g))) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .ret_vld   (vld_pipe[MEM_LAT]),
      .ret_lane  (lane_pipe[MEM_LAT]),
      .mem_rdata (mem_rdata),
      .rdata     (rdata_l[g]),
      .rvalid    (rvalid_l[g])
    );
  end

  assign u_rdata  = rdata_l[0];
  assign l_rdata  = rdata_l[1];
  assign u_rvalid = rvalid_l[0];
  assign l_rvalid = rvalid_l[1];
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb at MEM_LAT=1 with a one-cycle-latency memory model.

module tb_mem_port_arb;
  logic        clk = 1'b0;
  logic        rstn, flush;
  logic        u_req, l_req, u_we, l_we;
  logic [31:0] u_addr, l_addr, u_wdata, l_wdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] u_rdata, l_rdata;
  logic        u_rvalid, l_rvalid, interlock;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arb #(.MEM_LAT(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .u_req(u_req), .l_req(l_req), .u_we(u_we), .l_we(l_we),
    .u_addr(u_addr), .l_addr(l_addr), .u_wdata(u_wdata), .l_wdata(l_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .u_rdata(u_rdata), .l_rdata(l_rdata), .u_rvalid(u_rvalid), .l_rvalid(l_rvalid),
    .interlock(interlock)
  );

  always #5 clk = ~clk;

  // Memory model: one remembered store, otherwise a fixed pattern per address.
  logic        st_vld = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (st_vld && a == st_addr) return st_data;
    if (a == 32'h10) return 32'hAAAA_0001;
    return {16'hBEEF, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      st_vld  <= 1'b1;
      st_addr <= mem_addr;
      st_data <= mem_wdata;
    end
    mem_rdata <= rd_word(mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic no_req();
    u_req = 0; l_req = 0; u_we = 0; l_we = 0;
    u_addr = '0; l_addr = '0; u_wdata = '0; l_wdata = '0;
  endtask

  initial begin
    rstn = 0; flush = 0;
    no_req();
    tick(); tick();
    chk("rst_mem_en", mem_en, 0);      chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);  chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_u_rdata", u_rdata, 0);    chk("rst_l_rdata", l_rdata, 0);
    chk("rst_u_rvalid", u_rvalid, 0);  chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_interlock", interlock, 0);
    rstn = 1;
    tick();

    // Single upper load 0x10
    u_req = 1; u_addr = 32'h10;
    tick();
    chk("s_en", mem_en, 1); chk("s_addr", mem_addr, 32'h10); chk("s_we", mem_we, 0);
    chk("s_ilk", interlock, 0);
    no_req();
    tick();
    chk("s_en_off", mem_en, 0); chk("s_rv_early", u_rvalid, 0);
    tick();
    chk("s_u_rvalid", u_rvalid, 1); chk("s_u_rdata", u_rdata, 32'hAAAA_0001);
    chk("s_l_rvalid", l_rvalid, 0);
    tick();
    chk("s_rv_pulse", u_rvalid, 0); chk("s_rdata_hold", u_rdata, 32'hAAAA_0001);

    // Dual: upper store 0x20/0x55, lower load 0x20
    u_req = 1; u_we = 1; u_addr = 32'h20; u_wdata = 32'h55;
    l_req = 1; l_we = 0; l_addr = 32'h20;
    chk("d_ilk_c", interlock, 0);
    tick();
    chk("d_ilk_c1", interlock, 1); chk("d_en1", mem_en, 1); chk("d_we1", mem_we, 1);
    chk("d_addr1", mem_addr, 32'h20); chk("d_wdata1", mem_wdata, 32'h55);
    tick();
    chk("d_ilk_c2", interlock, 0); chk("d_en2", mem_en, 1); chk("d_we2", mem_we, 0);
    chk("d_addr2", mem_addr, 32'h20);
    no_req();
    tick();
    chk("d_en3", mem_en, 0); chk("d_l_rv_early", l_rvalid, 0); chk("d_u_rv3", u_rvalid, 0);
    tick();
    chk("d_l_rvalid", l_rvalid, 1); chk("d_l_rdata", l_rdata, 32'h55);
    chk("d_u_rvalid", u_rvalid, 0);
    tick();
    chk("d_l_rv_pulse", l_rvalid, 0); chk("d_u_rv5", u_rvalid, 0);

    // Dual loads 0x30/0x40, then single upper load 0x50 back-to-back
    u_req = 1; u_addr = 32'h30; l_req = 1; l_addr = 32'h40;
    tick();
    chk("b_en1", mem_en, 1); chk("b_addr1", mem_addr, 32'h30); chk("b_ilk1", interlock, 1);
    tick();
    chk("b_en2", mem_en, 1); chk("b_addr2", mem_addr, 32'h40); chk("b_ilk2", interlock, 0);
    no_req(); u_req = 1; u_addr = 32'h50;
    tick();
    chk("b_en3", mem_en, 1); chk("b_addr3", mem_addr, 32'h50);
    chk("b_u_rv3", u_rvalid, 1); chk("b_u_rd3", u_rdata, 32'hBEEF_0030); chk("b_l_rv3", l_rvalid, 0);
    no_req();
    tick();
    chk("b_en4", mem_en, 0);
    chk("b_l_rv4", l_rvalid, 1); chk("b_l_rd4", l_rdata, 32'hBEEF_0040); chk("b_u_rv4", u_rvalid, 0);
    tick();
    chk("b_u_rv5", u_rvalid, 1); chk("b_u_rd5", u_rdata, 32'hBEEF_0050); chk("b_l_rv5", l_rvalid, 0);
    tick();
    chk("b_u_rv6", u_rvalid, 0);

    // Lower-only load 0xA0
    l_req = 1; l_addr = 32'hA0;
    tick();
    chk("l_en", mem_en, 1); chk("l_addr", mem_addr, 32'hA0); chk("l_ilk", interlock, 0);
    no_req();
    tick();
    tick();
    chk("l_rvalid", l_rvalid, 1); chk("l_rdata", l_rdata, 32'hBEEF_00A0); chk("l_u_rv", u_rvalid, 0);

    // Dual loads 0x60/0x70, flush in C+1
    u_req = 1; u_addr = 32'h60; l_req = 1; l_addr = 32'h70;
    tick();
    chk("f_en1", mem_en, 1); chk("f_addr1", mem_addr, 32'h60); chk("f_ilk1", interlock, 1);
    flush = 1;
    tick();
    flush = 0; no_req();
    chk("f_en2", mem_en, 0); chk("f_ilk2", interlock, 0);
    chk("f_u_rv2", u_rvalid, 0); chk("f_l_rv2", l_rvalid, 0);
    tick();
    chk("f_en3", mem_en, 0); chk("f_u_rv3", u_rvalid, 0); chk("f_l_rv3", l_rvalid, 0);
    tick();
    chk("f_u_rv4", u_rvalid, 0); chk("f_l_rv4", l_rvalid, 0);

    // Flush in IDLE overrides a request sampled at the same edge
    u_req = 1; u_addr = 32'h80; flush = 1;
    tick();
    flush = 0; no_req();
    chk("fi_en", mem_en, 0);
    tick();
    chk("fi_rv", u_rvalid, 0);

    // Load 0x90, reset during its port cycle
    u_req = 1; u_addr = 32'h90;
    tick();
    chk("r_en1", mem_en, 1);
    no_req(); rstn = 0;
    tick();
    rstn = 1;
    chk("r_en", mem_en, 0); chk("r_we", mem_we, 0);
    chk("r_addr", mem_addr, 0); chk("r_wdata", mem_wdata, 0);
    chk("r_u_rdata", u_rdata, 0); chk("r_l_rdata", l_rdata, 0);
    chk("r_u_rv", u_rvalid, 0); chk("r_l_rv", l_rvalid, 0); chk("r_ilk", interlock, 0);
    tick();
    chk("r_u_rv3", u_rvalid, 0); chk("r_l_rv3", l_rvalid, 0);
    tick();
    chk("r_u_rv4", u_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
